// File: rtl/ctrl_pkg.sv
// Shared control-group types and forwarding-select encodings for the
// ID-to-WB control pipeline of the 5-stage core.
package ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic reg_dest;
        logic alu_op1;
        logic alu_op2;
        logic alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one EX-stage ALU operand; EX/MEM wins over MEM/WB.
module fwd_unit #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] mem_wreg_i,
    input  logic             wb_reg_write_i,
    input  logic [REG_W-1:0] wb_wreg_i,
    output logic [1:0]       sel_o
);
    import ctrl_pkg::*;

    logic mem_hit, wb_hit;

    assign mem_hit = mem_reg_write_i && (mem_wreg_i != '0) && (mem_wreg_i == src_i);
    assign wb_hit  = wb_reg_write_i  && (wb_wreg_i  != '0) && (wb_wreg_i  == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit)     sel_o = FWD_MEM;
        else if (wb_hit) sel_o = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Carries decoded control bits through ID/EX, EX/MEM, MEM/WB; handles load-use
// bubbles, IF flush on redirect, operand forwarding and event counters.
module ctrl_pipe_hazard #(
    parameter int REG_W = ctrl_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_reg_dest,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_op1,
    input  logic             id_alu_op2,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_jump,
    input  logic             id_if_flush,
    input  logic             id_branch_taken,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ex_reg_dest,
    output logic             ex_alu_op1,
    output logic             ex_alu_op2,
    output logic             ex_alu_src,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_write,
    output logic [REG_W-1:0] ex_wreg,
    output logic [REG_W-1:0] mem_wreg,
    output logic [REG_W-1:0] wb_wreg,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import ctrl_pkg::*;

    ex_ctrl_t         ex_ctl_q, ex_ctl_d;
    mem_ctrl_t        ex_mem_q, ex_mem_d, mem_mem_q;
    wb_ctrl_t         ex_wb_q, ex_wb_d, mem_wb_q, wb_wb_q;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [REG_W-1:0] ex_wreg_q, ex_wreg_d, mem_wreg_q, wb_wreg_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             stall, redirect;

    // Decoder hint only; redirect is derived from jump/branch outcome.
    logic unused_if_flush;
    assign unused_if_flush = id_if_flush;

    assign stall    = ex_mem_q.mem_read && (ex_wreg_q != '0) &&
                      ((ex_wreg_q == id_rs) || (ex_wreg_q == id_rt));
    assign redirect = id_jump | (id_branch & id_branch_taken);

    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    // A stalled redirect is re-presented next cycle, so it is simply deferred.
    assign ifid_flush = redirect & ~stall & reset_n;

    always_comb begin
        ex_ctl_d  = '{reg_dest: id_reg_dest, alu_op1: id_alu_op1,
                      alu_op2: id_alu_op2, alu_src: id_alu_src};
        ex_mem_d  = '{mem_read: id_mem_read, mem_write: id_mem_write};
        ex_wb_d   = '{mem_to_reg: id_mem_to_reg, reg_write: id_reg_write};
        ex_rs_d   = id_rs;
        ex_rt_d   = id_rt;
        ex_wreg_d = id_reg_dest ? id_rd : id_rt;
        if (stall) begin
            ex_ctl_d  = '0;
            ex_mem_d  = '0;
            ex_wb_d   = '0;
            ex_rs_d   = '0;
            ex_rt_d   = '0;
            ex_wreg_d = '0;
        end
    end

    assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = (ifid_flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctl_q    <= '0;
            ex_mem_q    <= '0;
            ex_wb_q     <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_wreg_q   <= '0;
            mem_mem_q   <= '0;
            mem_wb_q    <= '0;
            mem_wreg_q  <= '0;
            wb_wb_q     <= '0;
            wb_wreg_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_ctl_q    <= ex_ctl_d;
            ex_mem_q    <= ex_mem_d;
            ex_wb_q     <= ex_wb_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_wreg_q   <= ex_wreg_d;
            mem_mem_q   <= ex_mem_q;
            mem_wb_q    <= ex_wb_q;
            mem_wreg_q  <= ex_wreg_q;
            wb_wb_q     <= mem_wb_q;
            wb_wreg_q   <= mem_wreg_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src_i          (ex_rs_q),
        .mem_reg_write_i(mem_wb_q.reg_write),
        .mem_wreg_i     (mem_wreg_q),
        .wb_reg_write_i (wb_wb_q.reg_write),
        .wb_wreg_i      (wb_wreg_q),
        .sel_o          (fwd_a)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src_i          (ex_rt_q),
        .mem_reg_write_i(mem_wb_q.reg_write),
        .mem_wreg_i     (mem_wreg_q),
        .wb_reg_write_i (wb_wb_q.reg_write),
        .wb_wreg_i      (wb_wreg_q),
        .sel_o          (fwd_b)
    );

    assign ex_reg_dest   = ex_ctl_q.reg_dest;
    assign ex_alu_op1    = ex_ctl_q.alu_op1;
    assign ex_alu_op2    = ex_ctl_q.alu_op2;
    assign ex_alu_src    = ex_ctl_q.alu_src;
    assign mem_mem_read  = mem_mem_q.mem_read;
    assign mem_mem_write = mem_mem_q.mem_write;
    assign wb_mem_to_reg = wb_wb_q.mem_to_reg;
    assign wb_reg_write  = wb_wb_q.reg_write;
    assign ex_wreg       = ex_wreg_q;
    assign mem_wreg      = mem_wreg_q;
    assign wb_wreg       = wb_wreg_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench: an instruction-level pipeline model predicts every cycle's
// outputs; a negedge monitor pops and compares. Directed hazard cases plus random.
module tb_ctrl_pipe_hazard;
    localparam int RW = 5;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic reg_dest, branch, mem_read, mem_to_reg, alu_op1, alu_op2;
        logic mem_write, alu_src, reg_write, jump, if_flush, taken;
        logic [RW-1:0] rs, rt, rd;
    } ins_t;

    typedef struct packed {
        logic pcw, ifw, fl;
        logic [3:0] exc;
        logic [1:0] memc, wbc;
        logic [RW-1:0] exw, mw, ww;
        logic [1:0] fa, fb;
        logic [CW-1:0] sc, fc;
    } obs_t;

    logic clk, reset_n;
    logic id_reg_dest, id_branch, id_mem_read, id_mem_to_reg, id_alu_op1, id_alu_op2;
    logic id_mem_write, id_alu_src, id_reg_write, id_jump, id_if_flush, id_branch_taken;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic pc_write, ifid_write, ifid_flush;
    logic ex_reg_dest, ex_alu_op1, ex_alu_op2, ex_alu_src;
    logic mem_mem_read, mem_mem_write, wb_mem_to_reg, wb_reg_write;
    logic [RW-1:0] ex_wreg, mem_wreg, wb_wreg;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    ctrl_pipe_hazard #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_reg_dest(id_reg_dest), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_op1(id_alu_op1), .id_alu_op2(id_alu_op2),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_jump(id_jump), .id_if_flush(id_if_flush), .id_branch_taken(id_branch_taken),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ex_reg_dest(ex_reg_dest), .ex_alu_op1(ex_alu_op1), .ex_alu_op2(ex_alu_op2),
        .ex_alu_src(ex_alu_src), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
        .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t sb[$];
    ins_t m_ex, m_mem, m_wb;
    int   m_st, m_fl;
    logic last_pcw, last_ifw, last_fl;

    // ---------------- instruction constructors ----------------
    function automatic ins_t rtype(int s, int t, int d);
        ins_t x = '0;
        x.reg_dest = 1'b1; x.alu_op1 = 1'b1; x.reg_write = 1'b1;
        x.rs = RW'(s); x.rt = RW'(t); x.rd = RW'(d);
        return x;
    endfunction
    function automatic ins_t lw(int s, int t);
        ins_t x = '0;
        x.mem_read = 1'b1; x.mem_to_reg = 1'b1; x.alu_src = 1'b1; x.reg_write = 1'b1;
        x.rs = RW'(s); x.rt = RW'(t);
        return x;
    endfunction
    function automatic ins_t sw(int s, int t);
        ins_t x = '0;
        x.mem_write = 1'b1; x.alu_src = 1'b1; x.rs = RW'(s); x.rt = RW'(t);
        return x;
    endfunction
    function automatic ins_t beq(int s, int t, bit tk);
        ins_t x = '0;
        x.branch = 1'b1; x.alu_op2 = 1'b1; x.taken = tk; x.rs = RW'(s); x.rt = RW'(t);
        return x;
    endfunction
    function automatic ins_t jmp();
        ins_t x = '0;
        x.jump = 1'b1; x.if_flush = 1'b1;
        return x;
    endfunction
    function automatic ins_t rnd_ins();
        logic [31:0] r;
        ins_t x;
        int s = $urandom_range(0, 7);
        int t = $urandom_range(0, 7);
        int d = $urandom_range(0, 7);
        case ($urandom_range(0, 5))
            0: x = rtype(s, t, d);
            1: x = lw(s, t);
            2: x = sw(s, t);
            3: x = beq(s, t, 1'($urandom_range(0, 1)));
            4: x = jmp();
            default: begin
                r = $urandom;
                x = r[$bits(ins_t)-1:0];
                x.rs = RW'(s); x.rt = RW'(t); x.rd = RW'(d);
            end
        endcase
        return x;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] dst(ins_t i);
        return i.reg_dest ? i.rd : i.rt;
    endfunction
    function automatic logic m_stall(ins_t i);
        return m_ex.mem_read && dst(m_ex) != 0 && (dst(m_ex) == i.rs || dst(m_ex) == i.rt);
    endfunction
    function automatic logic [1:0] m_src(logic [RW-1:0] r);
        if (m_mem.reg_write && dst(m_mem) != 0 && dst(m_mem) == r) return 2'b10;
        if (m_wb.reg_write && dst(m_wb) != 0 && dst(m_wb) == r) return 2'b01;
        return 2'b00;
    endfunction
    function automatic obs_t model_out(ins_t i);
        obs_t o;
        logic st = m_stall(i);
        o.pcw  = !st;
        o.ifw  = !st;
        o.fl   = (i.jump | (i.branch & i.taken)) & !st;
        o.exc  = {m_ex.reg_dest, m_ex.alu_op1, m_ex.alu_op2, m_ex.alu_src};
        o.memc = {m_mem.mem_read, m_mem.mem_write};
        o.wbc  = {m_wb.mem_to_reg, m_wb.reg_write};
        o.exw  = dst(m_ex);
        o.mw   = dst(m_mem);
        o.ww   = dst(m_wb);
        o.fa   = m_src(m_ex.rs);
        o.fb   = m_src(m_ex.rt);
        o.sc   = CW'(m_st);
        o.fc   = CW'(m_fl);
        return o;
    endfunction
    task automatic model_step(ins_t i);
        logic st = m_stall(i);
        if (st && m_st < CMAX) m_st++;
        if ((i.jump | (i.branch & i.taken)) && !st && m_fl < CMAX) m_fl++;
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = st ? ins_t'('0) : i;
    endtask
    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_st = 0; m_fl = 0;
    endtask
    function automatic obs_t rst_obs();
        obs_t o = '0;
        o.pcw = 1'b1; o.ifw = 1'b1;
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.pcw = pc_write; o.ifw = ifid_write; o.fl = ifid_flush;
        o.exc = {ex_reg_dest, ex_alu_op1, ex_alu_op2, ex_alu_src};
        o.memc = {mem_mem_read, mem_mem_write};
        o.wbc = {wb_mem_to_reg, wb_reg_write};
        o.exw = ex_wreg; o.mw = mem_wreg; o.ww = wb_wreg;
        o.fa = fwd_a; o.fb = fwd_b; o.sc = stall_cnt; o.fc = flush_cnt;
        return o;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive(ins_t i);
        id_reg_dest = i.reg_dest; id_branch = i.branch; id_mem_read = i.mem_read;
        id_mem_to_reg = i.mem_to_reg; id_alu_op1 = i.alu_op1; id_alu_op2 = i.alu_op2;
        id_mem_write = i.mem_write; id_alu_src = i.alu_src; id_reg_write = i.reg_write;
        id_jump = i.jump; id_if_flush = i.if_flush; id_branch_taken = i.taken;
        id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    endtask

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(ins_t i, output logic st);
        drive(i);
        #1;
        st = m_stall(i);
        sb.push_back(model_out(i));
        last_pcw = pc_write; last_ifw = ifid_write; last_fl = ifid_flush;
        @(posedge clk);
        model_step(i);
        #1;
    endtask

    task automatic issue(ins_t i);
        logic st;
        int   n = 0;
        do begin
            cycle(i, st);
            n++;
        end while (st && n < 4);
    endtask

    // ---------------- monitor ----------------
    obs_t mon_e, mon_a;
    int   mon_cyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                mon_a = actual();
                n_cmp++;
                if (mon_a !== mon_e) begin
                    n_bad++;
                    $display("FAIL scoreboard cycle %0d: got %h expected %h", mon_cyc, mon_a, mon_e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic st;
        reset_n = 1'b0;
        model_reset();
        drive(rnd_ins());
        #12 chk("reset idle A", actual(), rst_obs());
        drive(rnd_ins());
        #10 chk("reset idle B", actual(), rst_obs());
        drive('0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycle('0, st);
        chk("post-reset counters", {stall_cnt, flush_cnt}, 0);

        // load-use
        cycle(lw(0, 5), st);
        cycle(rtype(5, 0, 6), st);
        chk("lu pc_write", last_pcw, 0);
        chk("lu ifid_write", last_ifw, 0);
        chk("lu bubble ex", {ex_reg_dest, ex_alu_op1, ex_alu_op2, ex_alu_src, ex_wreg}, 0);
        chk("lu stall_cnt", stall_cnt, 1);
        cycle(rtype(5, 0, 6), st);
        chk("lu resume", last_pcw, 1);

        // forwarding
        cycle(rtype(1, 2, 3), st);
        cycle(rtype(3, 3, 4), st);
        chk("fwd mem", {fwd_a, fwd_b}, 4'b1010);
        cycle(rtype(1, 2, 3), st);
        cycle(rtype(1, 2, 7), st);
        cycle(rtype(3, 3, 4), st);
        chk("fwd wb", {fwd_a, fwd_b}, 4'b0101);
        cycle(rtype(1, 2, 0), st);
        cycle(rtype(0, 0, 4), st);
        chk("fwd r0", {fwd_a, fwd_b}, 4'b0000);

        // redirect
        cycle(jmp(), st);
        chk("jump flush", last_fl, 1);
        chk("jump flush_cnt", flush_cnt, 1);
        cycle(beq(1, 2, 0), st);
        chk("beq nt flush", last_fl, 0);

        // stall plus redirect
        cycle(lw(0, 4), st);
        cycle(beq(4, 0, 1), st);
        chk("sr stall pc", last_pcw, 0);
        chk("sr stall flush", last_fl, 0);
        cycle(beq(4, 0, 1), st);
        chk("sr deferred flush", last_fl, 1);
        chk("sr counters", {stall_cnt, flush_cnt}, {8'd2, 8'd2});

        repeat (1500) issue(rnd_ins());

        // async reset in the middle of a stall
        cycle(rtype(1, 1, 1), st);
        cycle(lw(0, 4), st);
        drive(rtype(4, 1, 2));
        #1 chk("ms stall live", pc_write, 0);
        reset_n = 1'b0;
        #1 chk("ms async clear", actual(), rst_obs());
        model_reset();
        drive('0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycle(rtype(4, 4, 5), st);
        chk("ms first instr", last_pcw, 1);

        // counter saturation
        repeat (2 * ((1 << CW) + 3) + 1) cycle(lw(4, 4), st);
        chk("stall sat", stall_cnt, CMAX);
        repeat ((1 << CW) + 3) cycle(jmp(), st);
        chk("flush sat", flush_cnt, CMAX);
        chk("stall sat hold", stall_cnt, CMAX);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Receiving end of the ID-stage main decoder. Consumes the decoded control bits for the instruction in ID and carries them through ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles. Generates IF flush on taken jumps and branches.
- Produces forwarding selects for the EX-stage ALU operands.
- Sits between the decoder and the datapath pipeline registers of the 5-stage MIPS core.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- id_reg_dest, id_branch, id_mem_read, id_mem_to_reg, id_alu_op1, id_alu_op2, id_mem_write, id_alu_src, id_reg_write, id_jump, id_if_flush  in  1 each  decoder outputs for the ID instruction.
- id_branch_taken  in  1  ID-stage register comparator equal.
- id_rs, id_rt, id_rd  in  REG_W each  ID register fields.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero the IF/ID register next edge.
- ex_reg_dest, ex_alu_op1, ex_alu_op2, ex_alu_src  out  1 each  EX controls.
- mem_mem_read, mem_mem_write  out  1 each  MEM controls.
- wb_mem_to_reg, wb_reg_write  out  1 each  WB controls.
- ex_wreg, mem_wreg, wb_wreg  out  REG_W each  destination register per stage.
- fwd_a, fwd_b  out  2 each  ALU operand select.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset (async, reset_n=0):
  - All stage control bits and *_wreg are 0.
  - fwd_a and fwd_b are 00. Both counters are 0.
  - pc_write=1, ifid_write=1, ifid_flush=0, since they are combinational from cleared state.
- ID/EX stage register:
  - Holds the EX, MEM and WB control groups plus rs, rt and the destination.
  - ex_wreg = id_reg_dest ? id_rd : id_rt, captured at the edge.
  - EX/MEM and MEM/WB shift the MEM and WB groups and wreg forward each cycle unconditionally.
  - Each stage has 1-cycle latency.
- Load-use stall (combinational):
  - stall = ex_mem_read & (ex_wreg != 0) & (ex_wreg == id_rs | ex_wreg == id_rt).
  - ex_mem_read is internal, the ID/EX MemRead bit.
  - While stall: pc_write=0, ifid_write=0, and the ID/EX register loads all-zero controls (bubble) at the next edge.
  - Exactly one bubble per load-use pair.
- Flush (combinational):
  - redirect = id_jump | (id_branch & id_branch_taken).
  - ifid_flush = redirect & ~stall. A stalled ID instruction's redirect is deferred until the stall clears.
  - id_if_flush is a decoder hint only. It does not alone cause a flush.
  - The branch or jump itself proceeds into ID/EX normally (not bubbled).
- Forwarding, evaluated on the ID/EX rs/rt:
  - 10 when mem_reg_write & mem_wreg != 0 & mem_wreg matches.
  - Otherwise 01 when wb_reg_write & wb_wreg != 0 & wb_wreg matches.
  - Otherwise 00. EX/MEM has priority over MEM/WB.
- Counters:
  - stall_cnt increments on each edge where stall=1.
  - flush_cnt increments on each edge where ifid_flush=1.
  - Both saturate at all-ones (no wrap).
- Simultaneous events: stall dominates flush. A bubble never carries register-write or memory-write.
- Reset mid-operation: all in-flight controls are dropped immediately (async). The first post-reset instruction proceeds with no hazards.

Decomposition:
- Shared package ctrl_pkg holds:
  - Packed struct types ex_ctrl_t, mem_ctrl_t, wb_ctrl_t.
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_W.
- One natural sub-module: fwd_unit, the combinational forwarding compare, instantiated once per operand.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset_n=0 with random inputs, then release.
  - Required response: all stage outputs 0, pc_write=1, ifid_flush=0, counters 0.
- Load-use hazard:
  - Stimulus: LW id_rt=5, then next ID id_rs=5.
  - Required response: one cycle with pc_write=0 and ifid_write=0, a bubble in EX (ex_* and downstream all 0), stall_cnt=1, then normal flow.
- Forwarding:
  - Stimulus: R-type rd=3, then R-type rs=3 and rt=3.
  - Required response: fwd_a=fwd_b=10 in the consumer's EX cycle.
  - Stimulus: with one independent instruction between producer and consumer.
  - Required response: fwd_a=fwd_b=01.
  - Stimulus: destination register 0.
  - Required response: always 00.
- Redirect:
  - Stimulus: jump in ID.
  - Required response: ifid_flush=1 for that cycle, flush_cnt=1.
  - Stimulus: BEQ with id_branch_taken=0.
  - Required response: ifid_flush=0.
- Stall plus redirect:
  - Stimulus: LW rt=4, then BEQ rs=4 taken.
  - Required response: first cycle stall=1 with ifid_flush=0; next cycle ifid_flush=1.
- Async reset mid-stall, and saturation:
  - Stimulus: assert reset_n=0 during a stall.
  - Required response: outputs clear without waiting for a clock edge.
  - Stimulus: force 2^CNT_W+3 stalls.
  - Required response: stall_cnt holds at all-ones.
